qlearning_episode_ctrl: RTL and testbench

Top-level sequencer for the Q-learning agent. It handshakes observations (state, reward, terminal flag) in from the environment and pulses the Q-update accelerator enable. It triggers the policy generator, then handshakes the chosen action back out. It also counts steps and episodes and applies a per-episode epsilon decay schedule.

---
 rtl/qlearning_episode_ctrl.sv | 228 ++++++++++++++++++++++
 tb/tb_qlearning_episode_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qlearning_episode_ctrl.sv
// Episode sequencer for the Q-learning agent: observation/action handshakes,
// accelerator/policy pulses, step and episode counters, per-episode epsilon decay.
// Optional per-episode reward accumulator enabled by defining QLC_REWARD_ACC_EN.
module qlearning_episode_ctrl #(
    parameter int                STATE_W      = 6,
    parameter int                REWARD_W     = 16,
    parameter int                ACT_W        = 4,
    parameter int                EPS_W        = 16,
    parameter int                MAX_STEPS    = 64,
    parameter int                MAX_EPISODES = 1000,
    parameter logic [EPS_W-1:0]  EPS_INIT     = 16'hFFFF,
    parameter logic [EPS_W-1:0]  EPS_MIN      = 16'h0CCC,
    parameter int                EPS_SHIFT    = 4,
    parameter int                UPD_LAT      = 3,
    parameter int                POL_LAT      = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                env_valid,
    output logic                env_ready,
    input  logic [STATE_W-1:0]  env_state,
    input  logic [REWARD_W-1:0] env_reward,
    input  logic                env_done,
    output logic                act_valid,
    input  logic                act_ready,
    output logic [ACT_W-1:0]    act,
    output logic                agent_en,
    output logic                agent_start,
    output logic [STATE_W-1:0]  agent_state,
    output logic [REWARD_W-1:0] agent_reward,
    input  logic [ACT_W-1:0]    agent_action,
    output logic [EPS_W-1:0]    epsilon,
    output logic [15:0]         episode_cnt,
    output logic [15:0]         step_cnt,
    output logic                busy,
    output logic                run_done,
    output logic [23:0]         ep_reward_sum
);

    localparam int LAT_MAX = (UPD_LAT > POL_LAT) ? UPD_LAT : POL_LAT;
    localparam int LAT_W   = (LAT_MAX < 1) ? 1 : $clog2(LAT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT_EP, S_WAIT_OBS, S_UPDATE, S_POLICY, S_ISSUE, S_EP_END, S_FINISH
    } state_t;

    state_t              state_q, state_d;
    logic [LAT_W-1:0]    lat_q, lat_d;
    logic                first_q, first_d;
    logic                done_q, done_d;
    logic [STATE_W-1:0]  st_q, st_d;
    logic [REWARD_W-1:0] rw_q, rw_d;
    logic [ACT_W-1:0]    act_q, act_d;
    logic [EPS_W-1:0]    eps_q, eps_d;
    logic [15:0]         ep_q, ep_d;
    logic [15:0]         step_q, step_d;
    logic [EPS_W-1:0]    eps_dec, eps_next;
    logic                last_step, last_ep;

    // Subtracting a right-shifted copy can never underflow; only the floor needs a clamp.
    assign eps_dec   = eps_q - (eps_q >> EPS_SHIFT);
    assign eps_next  = (eps_dec < EPS_MIN) ? EPS_MIN : eps_dec;
    assign last_step = (step_q == 16'(MAX_STEPS - 1));
    assign last_ep   = (({1'b0, ep_q} + 17'd1) == 17'(MAX_EPISODES));

`ifdef QLC_REWARD_ACC_EN
    logic [23:0] acc_q, acc_d;
    logic [23:0] sum_q, sum_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            first_q <= 1'b1;
            done_q  <= 1'b0;
            st_q    <= '0;
            rw_q    <= '0;
            act_q   <= '0;
            eps_q   <= EPS_INIT;
            ep_q    <= '0;
            step_q  <= '0;
`ifdef QLC_REWARD_ACC_EN
            acc_q   <= '0;
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            first_q <= first_d;
            done_q  <= done_d;
            st_q    <= st_d;
            rw_q    <= rw_d;
            act_q   <= act_d;
            eps_q   <= eps_d;
            ep_q    <= ep_d;
            step_q  <= step_d;
`ifdef QLC_REWARD_ACC_EN
            acc_q   <= acc_d;
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        lat_d       = '0;
        first_d     = first_q;
        done_d      = done_q;
        st_d        = st_q;
        rw_d        = rw_q;
        act_d       = act_q;
        eps_d       = eps_q;
        ep_d        = ep_q;
        step_d      = step_q;
        env_ready   = 1'b0;
        act_valid   = 1'b0;
        agent_en    = 1'b0;
        agent_start = 1'b0;
`ifdef QLC_REWARD_ACC_EN
        acc_d       = acc_q;
        sum_d       = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_INIT_EP;
                    eps_d   = EPS_INIT;
                    ep_d    = '0;
                end
            end
            S_INIT_EP: begin
                step_d  = '0;
                first_d = 1'b1;
`ifdef QLC_REWARD_ACC_EN
                acc_d   = '0;
`endif
                state_d = S_WAIT_OBS;
            end
            S_WAIT_OBS: begin
                env_ready = 1'b1;
                if (env_valid) begin
                    st_d    = env_state;
                    rw_d    = env_reward;
                    done_d  = env_done;
`ifdef QLC_REWARD_ACC_EN
                    acc_d   = acc_q + {{(24-REWARD_W){env_reward[REWARD_W-1]}}, env_reward};
`endif
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                // The very first observation of an episode has no prior transition to learn from.
                agent_en = !first_q && (lat_q == '0);
                if (first_q || (lat_q == LAT_W'(UPD_LAT)))
                    state_d = (done_q || last_step) ? S_EP_END : S_POLICY;
                else
                    lat_d = lat_q + 1'b1;
            end
            S_POLICY: begin
                agent_start = (lat_q == '0);
                if (lat_q == LAT_W'(POL_LAT)) begin
                    act_d   = agent_action;
                    state_d = S_ISSUE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            S_ISSUE: begin
                act_valid = 1'b1;
                if (act_ready) begin
                    step_d  = (step_q == 16'hFFFF) ? step_q : step_q + 16'd1;
                    first_d = 1'b0;
                    state_d = S_WAIT_OBS;
                end
            end
            S_EP_END: begin
                ep_d    = (ep_q == 16'hFFFF) ? ep_q : ep_q + 16'd1;
                eps_d   = eps_next;
`ifdef QLC_REWARD_ACC_EN
                sum_d   = acc_q;
`endif
                state_d = last_ep ? S_FINISH : S_INIT_EP;
            end
            S_FINISH: begin
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Abort wins over everything: no handshake completes and all counters hold.
        if (abort && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            lat_d     = '0;
            first_d   = first_q;
            done_d    = done_q;
            st_d      = st_q;
            rw_d      = rw_q;
            act_d     = act_q;
            eps_d     = eps_q;
            ep_d      = ep_q;
            step_d    = step_q;
            env_ready = 1'b0;
            act_valid = 1'b0;
`ifdef QLC_REWARD_ACC_EN
            acc_d     = acc_q;
            sum_d     = sum_q;
`endif
        end
    end

    assign act          = act_q;
    assign agent_state  = st_q;
    assign agent_reward = rw_q;
    assign epsilon      = eps_q;
    assign episode_cnt  = ep_q;
    assign step_cnt     = step_q;
    assign busy         = (state_q != S_IDLE);
    assign run_done     = (state_q == S_FINISH);
`ifdef QLC_REWARD_ACC_EN
    assign ep_reward_sum = sum_q;
`else
    assign ep_reward_sum = '0;
`endif

endmodule

// File: tb/tb_qlearning_episode_ctrl.sv
// Directed bench for qlearning_episode_ctrl with a transaction-schedule model
// compared against the DUT on every falling clock edge.
module tb_qlearning_episode_ctrl;

    localparam int          MAX_STEPS    = 4;
    localparam int          MAX_EPISODES = 3;
    localparam logic [15:0] EPS_INIT     = 16'h1000;
    localparam logic [15:0] EPS_MIN      = 16'h0F80;
    localparam int          EPS_SHIFT    = 4;
    localparam int          UPD_LAT      = 3;
    localparam int          POL_LAT      = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, env_valid, env_done, act_ready;
    logic [5:0]  env_state;
    logic [15:0] env_reward;
    logic [3:0]  agent_action;
    logic        env_ready, act_valid, agent_en, agent_start, busy, run_done;
    logic [3:0]  act;
    logic [5:0]  agent_state;
    logic [15:0] agent_reward, epsilon, episode_cnt, step_cnt;
    logic [23:0] ep_reward_sum;

    always #5 clk = ~clk;

    qlearning_episode_ctrl #(
        .MAX_STEPS(MAX_STEPS), .MAX_EPISODES(MAX_EPISODES), .EPS_INIT(EPS_INIT),
        .EPS_MIN(EPS_MIN), .EPS_SHIFT(EPS_SHIFT), .UPD_LAT(UPD_LAT), .POL_LAT(POL_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .env_valid(env_valid), .env_ready(env_ready), .env_state(env_state),
        .env_reward(env_reward), .env_done(env_done),
        .act_valid(act_valid), .act_ready(act_ready), .act(act),
        .agent_en(agent_en), .agent_start(agent_start), .agent_state(agent_state),
        .agent_reward(agent_reward), .agent_action(agent_action), .epsilon(epsilon),
        .episode_cnt(episode_cnt), .step_cnt(step_cnt), .busy(busy),
        .run_done(run_done), .ep_reward_sum(ep_reward_sum)
    );

    int n_checks = 0;
    int n_errors = 0;
    int n_en = 0;
    int n_st = 0;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_checks++;
        if (a !== e) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, a, e, $time);
        end
    endtask

    // Model: the run is a schedule of cycle items that follow an accepted observation.
    typedef struct packed { logic en; logic st; logic latch; logic epend; logic init; } item_t;
    localparam int P_IDLE = 0, P_WAIT = 1, P_ISSUE = 2, P_FIN = 3;

    item_t       sched[$];
    int          ph, m_step, m_ep, m_eps;
    bit          m_first;
    logic [5:0]  m_state;
    logic [15:0] m_reward;
    logic [3:0]  m_act;
    logic [23:0] m_acc, m_sum;

    function automatic item_t mk(bit en, bit st, bit la, bit ee, bit in);
        item_t it;
        it.en = en; it.st = st; it.latch = la; it.epend = ee; it.init = in;
        return it;
    endfunction

    task automatic model_reset();
        ph = P_IDLE; sched.delete();
        m_step = 0; m_ep = 0; m_eps = int'(EPS_INIT); m_first = 1'b1;
        m_state = '0; m_reward = '0; m_act = '0; m_acc = '0; m_sum = '0;
    endtask

    task automatic model_step();
        item_t it;
        int d;
        if (ph != P_IDLE && abort) begin
            ph = P_IDLE; sched.delete();
        end else if (ph == P_IDLE) begin
            if (start && !abort) begin
                m_eps = int'(EPS_INIT); m_ep = 0; ph = P_WAIT;
                sched.push_back(mk(0, 0, 0, 0, 1));
            end
        end else if (sched.size() > 0) begin
            it = sched.pop_front();
            if (it.init) begin m_step = 0; m_first = 1'b1; m_acc = '0; end
            if (it.latch) m_act = agent_action;
            if (it.epend) begin
                if (m_ep < 65535) m_ep++;
                d = m_eps - m_eps / (1 << EPS_SHIFT);
                m_eps = (d < int'(EPS_MIN)) ? int'(EPS_MIN) : d;
                m_sum = m_acc;
                if (m_ep == MAX_EPISODES) ph = P_FIN;
                else begin ph = P_WAIT; sched.push_back(mk(0, 0, 0, 0, 1)); end
            end
        end else if (ph == P_WAIT) begin
            if (env_valid) begin
                m_state = env_state; m_reward = env_reward;
                m_acc = m_acc + {{8{env_reward[15]}}, env_reward};
                if (m_first) sched.push_back(mk(0, 0, 0, 0, 0));
                else begin
                    sched.push_back(mk(1, 0, 0, 0, 0));
                    repeat (UPD_LAT) sched.push_back(mk(0, 0, 0, 0, 0));
                end
                if (env_done || m_step == MAX_STEPS - 1) sched.push_back(mk(0, 0, 0, 1, 0));
                else begin
                    for (int i = 0; i <= POL_LAT; i++)
                        sched.push_back(mk(0, i == 0, i == POL_LAT, 0, 0));
                    ph = P_ISSUE;
                end
            end
        end else if (ph == P_ISSUE) begin
            if (act_ready) begin
                if (m_step < 65535) m_step++;
                m_first = 1'b0; ph = P_WAIT;
            end
        end else if (ph == P_FIN) begin
            if (!start) ph = P_IDLE;
        end
    endtask

    initial begin
        item_t head;
        bit    qe;
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            qe   = (sched.size() == 0);
            head = qe ? '0 : sched[0];
            chk("busy",         32'(busy),         32'(ph != P_IDLE));
            chk("env_ready",    32'(env_ready),    32'(qe && ph == P_WAIT && !abort));
            chk("act_valid",    32'(act_valid),    32'(qe && ph == P_ISSUE && !abort));
            chk("run_done",     32'(run_done),     32'(qe && ph == P_FIN));
            chk("agent_en",     32'(agent_en),     32'(head.en));
            chk("agent_start",  32'(agent_start),  32'(head.st));
            chk("act",          32'(act),          32'(m_act));
            chk("step_cnt",     32'(step_cnt),     32'(m_step));
            chk("episode_cnt",  32'(episode_cnt),  32'(m_ep));
            chk("epsilon",      32'(epsilon),      32'(m_eps));
            chk("agent_state",  32'(agent_state),  32'(m_state));
            chk("agent_reward", 32'(agent_reward), 32'(m_reward));
`ifdef QLC_REWARD_ACC_EN
            chk("ep_reward_sum", 32'(ep_reward_sum), 32'(m_sum));
`else
            chk("ep_reward_sum", 32'(ep_reward_sum), 32'd0);
`endif
            if (agent_en) n_en++;
            if (agent_start) n_st++;
            if (rst_n) model_step();
        end
    end

    task automatic sync();
        @(posedge clk); #1;
    endtask

    task automatic obs(input int s, input int r, input bit d);
        bit ok;
        ok = 1'b0;
        env_state = 6'(s); env_reward = 16'(r); env_done = d; env_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = env_ready;
        end
        sync();
        env_valid = 1'b0; env_done = 1'b0;
        if (!ok) begin n_checks++; n_errors++; $display("FAIL obs_timeout state=%0d", s); end
    endtask

    task automatic wait_sig(input int sel, input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            case (sel)
                0:       seen = act_valid;
                1:       seen = agent_start;
                2:       seen = agent_en;
                default: seen = run_done;
            endcase
        end
        if (!seen) begin n_checks++; n_errors++; $display("FAIL wait_timeout %s", nm); end
    endtask

    task automatic wait_ep(input int n);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = (int'(episode_cnt) == n);
        end
        if (!seen) begin n_checks++; n_errors++; $display("FAIL wait_episode got %0d expected %0d", episode_cnt, n); end
    endtask

    int e0, s0;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; env_valid = 1'b0; env_done = 1'b0;
        env_state = '0; env_reward = '0; act_ready = 1'b0; agent_action = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_epsilon", 32'(epsilon), 32'h1000);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_counts", {episode_cnt, step_cnt}, 32'd0);
        chk("rst_act", {27'd0, act_valid, act}, 32'd0);
        chk("rst_sum", 32'(ep_reward_sum), 32'd0);
        rst_n = 1'b1;
        sync();

        // Episode 1: four non-terminal observations, environment always accepts actions.
        act_ready = 1'b1; agent_action = 4'h5; e0 = n_en; s0 = n_st;
        start = 1'b1; sync(); start = 1'b0;
        obs(1, -5, 0); obs(2, 20, 0); obs(3, -1, 0); obs(4, 0, 0);
        wait_ep(1);
        chk("ep1_episode_cnt", 32'(episode_cnt), 32'd1);
        chk("ep1_step_cnt", 32'(step_cnt), 32'd3);
        chk("ep1_epsilon_clamp", 32'(epsilon), 32'h0F80);
        chk("ep1_agent_en_pulses", 32'(n_en - e0), 32'd3);
        chk("ep1_agent_start_pulses", 32'(n_st - s0), 32'd3);
`ifdef QLC_REWARD_ACC_EN
        chk("ep1_reward_sum", 32'(ep_reward_sum), 32'd14);
`else
        chk("ep1_reward_sum", 32'(ep_reward_sum), 32'd0);
`endif
        sync();

        // Episode 2: stalled action, then a terminal second observation.
        act_ready = 1'b0; agent_action = 4'h9; e0 = n_en; s0 = n_st;
        obs(5, 7, 0);
        wait_sig(0, "act_valid");
        repeat (5) begin
            @(negedge clk);
            chk("stall_act_valid", 32'(act_valid), 32'd1);
            chk("stall_act", 32'(act), 32'h9);
            chk("stall_step_cnt", 32'(step_cnt), 32'd0);
        end
        sync(); act_ready = 1'b1;
        sync(); act_ready = 1'b0;
        @(negedge clk);
        chk("accept_step_cnt", 32'(step_cnt), 32'd1);
        sync();
        obs(6, 1, 1);
        wait_ep(2);
        chk("term_step_cnt", 32'(step_cnt), 32'd1);
        chk("term_agent_en", 32'(n_en - e0), 32'd1);
        chk("term_agent_start", 32'(n_st - s0), 32'd1);
        chk("ep2_epsilon_floor", 32'(epsilon), 32'h0F80);
        sync();

        // Abort while the policy is running.
        act_ready = 1'b1;
        obs(7, 2, 0);
        wait_sig(1, "agent_start");
        sync(); abort = 1'b1;
        @(negedge clk);
        sync(); abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_episode_held", 32'(episode_cnt), 32'd2);
        chk("abort_eps_held", 32'(epsilon), 32'h0F80);
        sync();

        // Restart, then asynchronous reset in the middle of an update.
        start = 1'b1; sync(); start = 1'b0;
        obs(8, 3, 0);
        chk("restart_episode_cnt", 32'(episode_cnt), 32'd0);
        chk("restart_epsilon", 32'(epsilon), 32'h1000);
        obs(9, 4, 0);
        wait_sig(2, "agent_en");
        #1 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_epsilon", 32'(epsilon), 32'h1000);
        chk("arst_state_reward", {10'd0, agent_state, agent_reward}, 32'd0);
        chk("arst_counts", {step_cnt, episode_cnt}, 32'd0);
        chk("arst_pulses", {28'd0, agent_en, agent_start, act_valid, env_ready}, 32'd0);
        @(negedge clk);
        sync(); rst_n = 1'b1;
        sync();

        // Full run to FINISH with one terminal observation per episode, start held high.
        start = 1'b1; sync();
        for (int i = 0; i < MAX_EPISODES; i++) obs(10 + i, i, 1);
        wait_sig(3, "run_done");
        repeat (3) begin
            @(negedge clk);
            chk("finish_run_done", 32'(run_done), 32'd1);
            chk("finish_episode_cnt", 32'(episode_cnt), 32'd3);
        end
        sync(); start = 1'b0;
        sync();
        @(negedge clk);
        chk("finish_idle_busy", 32'(busy), 32'd0);
        chk("finish_idle_run_done", 32'(run_done), 32'd0);
        chk("finish_episode_held", 32'(episode_cnt), 32'd3);
        chk("finish_eps_held", 32'(epsilon), 32'h0F80);
        sync();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
